// File: rtl/decode_stage_pkg.sv
// Shared types and opcode constants for the decode stage and its decoder.
package decode_stage_pkg;

  localparam logic [7:0] OP_RET       = 8'hC3;
  localparam logic [7:0] OP_NOP       = 8'h90;
  localparam logic [7:0] OP_HLT       = 8'hF4;
  localparam logic [7:0] OP_ADD_RR    = 8'h01;
  localparam logic [7:0] OP_MOV_RR    = 8'h89;
  localparam logic [7:0] OP_ADD_I8    = 8'h83;
  localparam logic [7:0] OP_MOV_EAX_I = 8'hB8;
  localparam logic [7:0] OP_MOV_ECX_I = 8'hB9;
  localparam logic [7:0] OP_ADD_EAX_I = 8'h05;
  localparam logic [7:0] OP_JMP       = 8'hE9;

  typedef struct packed {
    logic [39:0] instr;
    logic [31:0] pc;
    logic [2:0]  length;
  } q_entry_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [31:0] imm;
    logic        has_imm;
    logic        illegal;
    logic [2:0]  length;
  } dec_t;

endpackage

// File: rtl/decode_stage_decoder.sv
// Combinational field decode of one queue entry, plus the relative jump target.
module instr_decoder
  import decode_stage_pkg::*;
(
  input  q_entry_t    entry,
  output dec_t        dec,
  output logic [31:0] target
);

  logic [7:0]  op;
  logic [7:0]  modrm;
  logic [31:0] imm32;

  assign op     = entry.instr[7:0];
  assign modrm  = entry.instr[15:8];
  assign imm32  = entry.instr[39:8];
  assign target = entry.pc + 32'd5 + imm32;

  always_comb begin
    dec        = '0;
    dec.opcode = op;
    dec.length = entry.length;
    case (op)
      OP_RET, OP_NOP, OP_HLT: ;
      OP_ADD_RR, OP_MOV_RR: begin
        if (modrm[7:6] == 2'b11) begin
          dec.rd = modrm[2:0];
          dec.rs = modrm[5:3];
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_ADD_I8: begin
        // Only the register-direct /0 form is supported.
        if (modrm[7:6] == 2'b11 && modrm[5:3] == 3'b000) begin
          dec.rd      = modrm[2:0];
          dec.imm     = {{24{entry.instr[23]}}, entry.instr[23:16]};
          dec.has_imm = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_MOV_EAX_I, OP_MOV_ECX_I: begin
        dec.rd      = op[2:0];
        dec.imm     = imm32;
        dec.has_imm = 1'b1;
      end
      OP_ADD_EAX_I, OP_JMP: begin
        dec.imm     = imm32;
        dec.has_imm = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// In-order instruction queue fed by fetch; decodes the head and drives
// redirect/halt feedback to fetch.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_valid,
  input  logic [39:0] f_instr,
  input  logic [31:0] f_pc,
  input  logic [2:0]  f_length,
  output logic        f_ready,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [7:0]  d_opcode,
  output logic [2:0]  d_rd,
  output logic [2:0]  d_rs,
  output logic [31:0] d_imm,
  output logic        d_has_imm,
  output logic [31:0] d_pc,
  output logic [2:0]  d_length,
  output logic        d_illegal,
  output logic        redirect,
  output logic [31:0] redirect_target,
  output logic        halted
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  q_entry_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  q_entry_t    head;
  dec_t        dec, dec_out;
  logic [31:0] target;
  logic        push, pop, pop_jmp, pop_hlt, flush;

  assign head = mem[rd_ptr];

  instr_decoder u_dec (
    .entry  (head),
    .dec    (dec),
    .target (target)
  );

  assign d_valid = (count != '0);
  assign f_ready = (count < FULL) && !halted && !redirect;
  assign push    = f_valid && f_ready;
  assign pop     = d_valid && d_ready;
  assign pop_jmp = pop && (dec.opcode == OP_JMP);
  assign pop_hlt = pop && (dec.opcode == OP_HLT);
  // Retiring a jump or halt discards everything younger, including a same-edge push.
  assign flush   = pop_jmp || pop_hlt;

  assign dec_out   = d_valid ? dec : '0;
  assign d_opcode  = dec_out.opcode;
  assign d_rd      = dec_out.rd;
  assign d_rs      = dec_out.rs;
  assign d_imm     = dec_out.imm;
  assign d_has_imm = dec_out.has_imm;
  assign d_illegal = dec_out.illegal;
  assign d_length  = dec_out.length;
  assign d_pc      = d_valid ? head.pc : '0;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= '{instr: f_instr, pc: f_pc, length: f_length};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      redirect        <= 1'b0;
      redirect_target <= '0;
      halted          <= 1'b0;
    end else begin
      redirect <= pop_jmp;
      if (pop_jmp) redirect_target <= target;
      if (pop_hlt) halted <= 1'b1;
      if (flush) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized + directed bench for decode_stage with a queue-based reference model.
module tb_decode_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_valid = 1'b0;
  logic [39:0] f_instr = '0;
  logic [31:0] f_pc = '0;
  logic [2:0]  f_length = '0;
  logic        d_ready = 1'b0;
  logic        f_ready, d_valid, d_has_imm, d_illegal, redirect, halted;
  logic [7:0]  d_opcode;
  logic [2:0]  d_rd, d_rs, d_length;
  logic [31:0] d_imm, d_pc, redirect_target;

  decode_stage #(.DEPTH(DEPTH), .PTR_W(1)) dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc),
    .f_length(f_length), .f_ready(f_ready), .d_valid(d_valid), .d_ready(d_ready),
    .d_opcode(d_opcode), .d_rd(d_rd), .d_rs(d_rs), .d_imm(d_imm),
    .d_has_imm(d_has_imm), .d_pc(d_pc), .d_length(d_length), .d_illegal(d_illegal),
    .redirect(redirect), .redirect_target(redirect_target), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  rd, rs, len;
    logic [31:0] imm, pc, target;
    logic        has_imm, illegal;
  } exp_t;

  exp_t        sb[$];
  bit          m_halt, m_redir;
  logic [31:0] m_tgt;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the opcode table.
  function automatic exp_t ref_decode(logic [39:0] w, logic [31:0] pc, logic [2:0] len);
    exp_t        e;
    logic [7:0]  op = w[7:0];
    logic [7:0]  m  = w[15:8];
    logic [7:0]  i8 = w[23:16];
    logic [31:0] i32 = w[39:8];
    e = '{default: '0};
    e.op = op; e.pc = pc; e.len = len;
    e.target = pc + 32'd5 + i32;
    if (op == 8'hC3 || op == 8'h90 || op == 8'hF4) begin
    end else if (op == 8'h01 || op == 8'h89) begin
      if (m[7:6] == 2'b11) begin e.rd = m[2:0]; e.rs = m[5:3]; end
      else e.illegal = 1;
    end else if (op == 8'h83) begin
      if (m[7:6] == 2'b11 && m[5:3] == 3'd0) begin
        e.rd = m[2:0]; e.imm = 32'($signed(i8)); e.has_imm = 1;
      end else e.illegal = 1;
    end else if (op == 8'hB8 || op == 8'hB9) begin
      e.rd = (op == 8'hB9) ? 3'd1 : 3'd0; e.imm = i32; e.has_imm = 1;
    end else if (op == 8'h05 || op == 8'hE9) begin
      e.imm = i32; e.has_imm = 1;
    end else e.illegal = 1;
    return e;
  endfunction

  // Monitor: compare DUT state to model at negedge, then advance model across the next edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      bit   exp_ready, pop, push, flush;
      exp_t h;
      exp_ready = (sb.size() < DEPTH) && !m_halt && !m_redir;
      chk("f_ready", f_ready, exp_ready);
      chk("d_valid", d_valid, sb.size() != 0);
      chk("redirect", redirect, m_redir);
      chk("halted", halted, m_halt);
      if (m_redir) chk("redirect_target", redirect_target, m_tgt);
      if (sb.size() != 0) h = sb[0]; else h = '{default: '0};
      chk("d_opcode", d_opcode, h.op);
      chk("d_rd", d_rd, h.rd);
      chk("d_rs", d_rs, h.rs);
      chk("d_imm", d_imm, h.imm);
      chk("d_has_imm", d_has_imm, h.has_imm);
      chk("d_illegal", d_illegal, h.illegal);
      chk("d_pc", d_pc, h.pc);
      chk("d_length", d_length, h.len);
      pop   = (sb.size() != 0) && d_ready;
      push  = f_valid && exp_ready;
      flush = pop && (h.op == 8'hE9 || h.op == 8'hF4);
      m_redir = pop && h.op == 8'hE9;
      if (m_redir) m_tgt = h.target;
      if (pop && h.op == 8'hF4) m_halt = 1;
      if (pop) void'(sb.pop_front());
      if (flush) sb.delete();
      else if (push) sb.push_back(ref_decode(f_instr, f_pc, f_length));
    end
  end

  task automatic drive(bit fv, logic [39:0] ins, logic [31:0] pc, logic [2:0] len, bit dr);
    @(posedge clk); #1;
    f_valid = fv; f_instr = ins; f_pc = pc; f_length = len; d_ready = dr;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_f_ready"}, f_ready, 1);
    chk({tag, "_d_valid"}, d_valid, 0);
    chk({tag, "_redirect"}, redirect, 0);
    chk({tag, "_target"}, redirect_target, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_opcode"}, d_opcode, 0);
    chk({tag, "_imm"}, d_imm, 0);
    chk({tag, "_illegal"}, d_illegal, 0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic async_reset();
    @(posedge clk); #3;
    rst = 1'b1; f_valid = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    sb.delete(); m_halt = 0; m_redir = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    m_halt = 0; m_redir = 0; m_tgt = '0;
    #2 check_reset_outputs("rst");
    #9 rst = 1'b0;

    drive(1, 40'h12345678B8, 32'h0, 3'd5, 1);
    repeat (2) drive(0, '0, '0, '0, 1);

    drive(1, 40'h0000FFC183, 32'h10, 3'd3, 1);
    drive(1, 40'h000000D801, 32'h13, 3'd2, 1);
    repeat (2) drive(0, '0, '0, '0, 1);

    for (int i = 0; i < 3; i++) drive(1, {32'hA0 + i, 8'hB9}, 32'h20 + 5 * i, 3'd5, 0);
    for (int i = 0; i < 3; i++) drive(1, {32'hB0 + i, 8'hB8}, 32'h40 + 5 * i, 3'd5, 1);
    repeat (3) drive(0, '0, '0, '0, 1);

    drive(1, 40'hFFFFFFFBE9, 32'h100, 3'd5, 0);
    drive(1, 40'h0000000090, 32'h105, 3'd1, 0);
    repeat (4) drive(0, '0, '0, '0, 1);

    drive(1, 40'h00000000F4, 32'h200, 3'd1, 0);
    drive(1, 40'h0000000090, 32'h201, 3'd1, 0);
    repeat (4) drive(1, 40'h0000000090, 32'h202, 3'd1, 1);
    async_reset();

    drive(1, 40'h000000000F, 32'h300, 3'd2, 1);
    drive(1, 40'h0000000001, 32'h302, 3'd2, 1);
    drive(1, 40'h12345678B8, 32'h304, 3'd5, 0);
    drive(1, 40'h00000001B9, 32'h309, 3'd5, 0);
    async_reset();

    for (int c = 0; c < 3000; c++) begin
      logic [39:0] w;
      logic [7:0]  op;
      int          k;
      w = {$urandom(), 8'(($urandom() & 32'hFF))};
      k = $urandom_range(0, 15);
      case (k)
        0: op = 8'hC3;  1: op = 8'h90;  2: op = 8'h01;  3: op = 8'h89;
        4: op = 8'h83;  5: op = 8'hB8;  6: op = 8'hB9;  7: op = 8'h05;
        8: op = 8'hE9;  9: op = ($urandom_range(0, 3) == 0) ? 8'hF4 : 8'h90;
        10: op = 8'h0F; 11: op = 8'($urandom());
        12: op = 8'h01; 13: op = 8'h83; default: op = 8'h89;
      endcase
      w[7:0] = op;
      if ($urandom_range(0, 3) != 0) w[15:14] = 2'b11;
      if (op == 8'h83 && $urandom_range(0, 2) != 0) w[13:11] = 3'b000;
      drive($urandom_range(0, 2) != 0, w, $urandom(), 3'($urandom()), $urandom_range(0, 3) != 0);
      if (m_halt && $urandom_range(0, 5) == 0) async_reset();
      else if (c % 700 == 699) async_reset();
    end
    repeat (2) drive(0, '0, '0, '0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Consumer side of the fetch interface. Accepts fetched 40-bit instruction windows with PC and length into a small in-order queue.
- Decodes the queue head into register, immediate, jump and halt fields, and presents them downstream with a valid/ready handshake.
- Provides the fetch stage with backpressure (fetch write enable), a one-cycle jump redirect pulse, and a sticky halt.

Parameters:
- DEPTH, 2, queue entries (power of two, ≥2).
- PTR_W, 1, log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- f_valid  in  1  fetch presents an instruction this cycle
- f_instr  in  40  instruction window, little endian, opcode in [7:0]
- f_pc  in  32  PC of f_instr
- f_length  in  3  length computed by fetch
- f_ready  out  1  queue can accept; drives fetch pc_we
- d_valid  out  1  decoded head valid
- d_ready  in  1  downstream accepts head
- d_opcode  out  8  head opcode
- d_rd  out  3  destination register
- d_rs  out  3  source register
- d_imm  out  32  immediate, sign-extended
- d_has_imm  out  1  d_imm meaningful
- d_pc  out  32  head PC
- d_length  out  3  head length
- d_illegal  out  1  unknown opcode or bad ModRM
- redirect  out  1  one-cycle pulse, jump retired downstream
- redirect_target  out  32  jump target, valid with redirect
- halted  out  1  sticky halt, drives fetch is_halt

Behaviour:
- Reset values: queue empty, pointers and count 0, f_ready=1, d_valid=0, redirect=0, redirect_target=0, halted=0. Decoded outputs are 0 while d_valid=0.
- Enqueue: f_valid && f_ready writes {instr, pc, length} at wr_ptr on the clock edge.
- f_ready = (count < DEPTH) && !halted && !redirect. There is no bypass when full: a simultaneous pop frees the slot only on the next cycle.
- Latency: an entry written at edge N is visible on d_valid after edge N, i.e. one cycle.
- Decoded outputs are combinational from the head entry. d_valid = (count != 0).
- Dequeue: d_valid && d_ready advances rd_ptr. Simultaneous push and pop leave count unchanged. Pointers wrap modulo DEPTH.
- Decode (op = instr[7:0], modrm = instr[15:8]):
  - C3, 90, F4: no operands.
  - 01 (ADD) and 89 (MOV): rd = modrm[2:0], rs = modrm[5:3]. Illegal if modrm[7:6] != 2'b11.
  - 83 (ADD imm8): rd = modrm[2:0], imm = sign-extended instr[23:16]. Illegal unless modrm[7:6] = 11 and modrm[5:3] = 000.
  - B8, B9: rd = op[2:0], imm = instr[39:8].
  - 05: rd = 0, imm = instr[39:8].
  - E9: imm = instr[39:8]; target = pc + 5 + imm, 32-bit wrap-around.
  - Any other opcode: d_illegal = 1, all fields 0.
- Jump: when an E9 is dequeued, the following cycle has redirect=1 and redirect_target latched.
  - On that same dequeue edge, all other queue entries (wrong path) are flushed: count=0, rd_ptr=wr_ptr.
  - A fetch push on that edge is discarded.
- Halt: when an F4 is dequeued, halted sets on that edge and stays set until rst.
  - Entries remaining in the queue are flushed and d_valid drops.
  - Pushes on that edge are discarded.
- d_length is passed through unchanged. Mismatch checking is left to verification.
- Reset asserted mid-operation clears the queue, redirect and halted immediately (asynchronous), with no partial handshakes.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RET=C3, OP_NOP=90, OP_HLT=F4, OP_ADD_RR=01, OP_MOV_RR=89, OP_ADD_I8=83, OP_MOV_EAX_I=B8, OP_MOV_ECX_I=B9, OP_ADD_EAX_I=05, OP_JMP=E9
  - the queue entry typedef {instr, pc, length}
  - the decoded-bundle typedef.
- One sub-module: instr_decoder, purely combinational (entry in, decoded bundle plus target out). Queue, control and redirect/halt live in decode_stage.

Test Plan:
- Reset then push B8 78 56 34 12 at pc=0 with d_ready=1 → next cycle d_valid=1, rd=0, imm=0x12345678, d_has_imm=1, d_pc=0, then empty.
- Push 83 C1 FF, then 01 D8 → first rd=1, imm=0xFFFFFFFF; second rd=0, rs=3.
- Hold d_ready=0 and push 3 entries → f_ready=0 after 2. Then assert d_ready and push together → count stays 2 and FIFO order is preserved.
- Push E9 FB FF FF FF at pc=0x100, followed by a NOP; accept E9 → redirect=1 for exactly one cycle with target=0x100, NOP flushed, d_valid=0.
- Push F4 then 90 and accept F4 → halted=1 sticky, f_ready=0, NOP never presented. Assert rst → halted=0.
- Push opcode 0x0F, and separately 01 with modrm 0x00 → d_illegal=1 with fields 0. Assert rst asynchronously mid-stream → all outputs at reset values immediately.
